// File: rtl/spi_flash_read_ctrl.sv
// Flash read sequencer: drives a byte-level SPI engine through opcode, 24-bit address,
// dummy bytes and LEN data bytes under one CS, streaming data bytes out with a watchdog abort.
module spi_flash_read_ctrl #(
  parameter int DUMMY_BYTES = 0,
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 64,
  parameter int CS_GAP_CYC  = 4
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       opcode,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             timeout,
  output logic             spi_enabled,
  output logic [7:0]       spi_data_in,
  output logic             spi_continue_read,
  input  logic             spi_busy,
  input  logic [7:0]       spi_data_out
);

  localparam int IW = LEN_W + 3;
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(CS_GAP_CYC + 2);
  localparam logic [IW-1:0] DATA_START = IW'(4 + DUMMY_BYTES);
  localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(CS_GAP_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_XFER1, S_WAIT, S_NEXT, S_FINISH, S_ABORT
  } state_t;

  state_t state, state_nx;

  logic [7:0]       opcode_q;
  logic [23:0]      addr_q;
  logic [LEN_W-1:0] len_q;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    last_idx;
  logic [WW-1:0]    wdog;
  logic [GW-1:0]    gap_cnt;
  logic             seen_busy;
  logic             zero_done;
  logic             byte_cmpl;
  logic             is_last;
  logic             data_phase;
  logic [7:0]       cur_byte;

  assign last_idx   = IW'(len_q) + IW'(3 + DUMMY_BYTES);
  assign is_last    = (idx == last_idx);
  assign data_phase = (idx >= DATA_START);
  assign byte_cmpl  = seen_busy && !spi_busy;

  always_comb begin
    cur_byte = 8'h00;
    if (idx == IW'(0))      cur_byte = opcode_q;
    else if (idx == IW'(1)) cur_byte = addr_q[23:16];
    else if (idx == IW'(2)) cur_byte = addr_q[15:8];
    else if (idx == IW'(3)) cur_byte = addr_q[7:0];
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start && len != '0) state_nx = (gap_cnt != '0) ? S_GAP : S_XFER1;
      S_GAP:    if (gap_cnt == '0) state_nx = S_XFER1;
      S_XFER1:  state_nx = S_WAIT;
      S_WAIT: begin
        if (byte_cmpl)              state_nx = is_last ? S_FINISH : S_NEXT;
        else if (wdog == WDOG_LAST) state_nx = S_ABORT;
      end
      S_NEXT:   state_nx = S_WAIT;
      S_FINISH: state_nx = S_IDLE;
      S_ABORT:  state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    spi_enabled       = (state == S_XFER1) || (state == S_WAIT) || (state == S_NEXT);
    busy              = spi_enabled || (state == S_GAP);
    spi_continue_read = (state == S_NEXT);
    done              = (state == S_FINISH) || (state == S_ABORT) || zero_done;
    spi_data_in       = spi_enabled ? cur_byte : 8'h00;
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      opcode_q  <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      idx       <= '0;
      wdog      <= '0;
      gap_cnt   <= '0;
      seen_busy <= 1'b0;
      zero_done <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      rd_valid  <= 1'b0;
      zero_done <= 1'b0;

      if (state == S_IDLE && start) begin
        if (len != '0) begin
          opcode_q <= opcode;
          addr_q   <= addr;
          len_q    <= len;
          idx      <= '0;
          timeout  <= 1'b0;
        end else begin
          zero_done <= 1'b1;
        end
      end

      if (state == S_XFER1 || state == S_NEXT) seen_busy <= 1'b0;
      else if (state == S_WAIT && spi_busy)    seen_busy <= 1'b1;

      // Watchdog restarts for every byte since each byte passes through XFER1 or NEXT.
      if (state == S_WAIT) wdog <= wdog + 1'b1;
      else                 wdog <= '0;

      if (state == S_WAIT && byte_cmpl) begin
        if (data_phase) begin
          rd_data  <= spi_data_out;
          rd_valid <= 1'b1;
        end
        if (!is_last) idx <= idx + 1'b1;
      end

      if (state == S_WAIT && state_nx == S_ABORT) timeout <= 1'b1;

      if (state == S_WAIT && (state_nx == S_FINISH || state_nx == S_ABORT))
        gap_cnt <= GAP_LOAD;
      else if (gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule
